sd_crc16_lanes: RTL
===================

Name: sd_crc16_lanes

Overview:
Multi-lane serial CRC16 engine (polynomial x^16 + x^12 + x^5 + 1, init 0) for the SD data-line driver. It runs one independent CRC per DAT line for 1-bit or 4-bit bus modes. It counts the block length itself. In generate mode it appends the CRC to the transmit stream; in check mode it compares the received CRC against the computed one and reports per-lane errors.

Parameters:
LANES, 4, number of DAT lines, one CRC16 register per lane (1..8).
BLOCK_BITS, 1024, payload bits per lane per block (512 bytes / LANES*8 lanes).
CNT_W, 11, width of the payload bit counter; must satisfy 2^CNT_W > BLOCK_BITS.

Ports:
iclk  input  1  clock; all logic on rising edge.
irst_n  input  1  asynchronous active-low reset.
istart  input  1  one-cycle pulse that begins a block; ignored when obusy=1.
imode  input  1  sampled with istart: 0 = generate (TX), 1 = check (RX).
ivalid  input  1  bit-enable; the engine advances only on cycles with ivalid=1 (stall otherwise).
idata  input  LANES  payload bit per lane, then received CRC bits in check mode.
ocrc  output  LANES  CRC bit per lane during the TX unload phase, MSB (crc[15]) first.
ocrc_valid  output  1  high while ocrc carries CRC bits.
obusy  output  1  high from the istart cycle+1 until odone.
odone  output  1  one-cycle pulse at end of block.
ocrc_err  output  LANES  per-lane mismatch flags, valid at odone, held until next istart.

Behaviour:
- Reset (irst_n=0, async): state IDLE; all CRC registers and counters = 0. ocrc=0, ocrc_valid=0, obusy=0, odone=0, ocrc_err=0.
- States and transitions:
  - IDLE: istart=1 clears the CRC registers, bit counter and ocrc_err; latches imode; goes to CALC.
  - CALC: on each ivalid=1, per lane: fb = idata[l]^crc[15]; crc <= {crc[14:0],0} ^ (fb ? 16'h1021 : 0); counter+1. On the ivalid cycle where the counter = BLOCK_BITS-1, go to UNLOAD (mode 0) or CHECK (mode 1) and reset the tail counter to 0.
  - UNLOAD: ocrc_valid=1 and ocrc[l]=crc[15] combinationally. Each ivalid=1 shifts crc left, inserting 0, and increments the tail counter. After the 16th shift, go to DONE. With ivalid=0, ocrc holds its value.
  - CHECK: on each ivalid=1, per lane, if idata[l] != crc[15] then ocrc_err[l] <= 1 (sticky). crc shifts left, inserting 0. After 16 bits, go to DONE. ocrc_valid stays 0.
  - DONE: odone=1 for exactly one cycle, obusy=0; then IDLE. ocrc_err stays held.
- Latency: the first CRC bit is on ocrc in the cycle after the last payload bit is accepted. odone is asserted in the cycle after the 16th tail bit.
- istart while busy: ignored, with no effect on state or registers.
- istart in the DONE cycle: ignored. It is accepted from IDLE only, so back-to-back blocks are spaced by at least 1 idle cycle.
- Lanes are fully independent; each lane's register depends only on its own idata bit.
- Reset asserted mid-block aborts immediately to reset values. No odone is produced.
- Unused tail-counter and bit-counter bits are ignored; counters never wrap within a block.

Test Plan:
- LANES=1, BLOCK_BITS=4096, mode 0, 512 bytes of 0xFF with ivalid=1 continuously → ocrc serial 0x7FA1 MSB first over 16 cycles, ocrc_valid high for 16 cycles, odone on the next cycle.
- LANES=4, mode 0, all-zero payload → all lanes output 0x0000. Then the same block in mode 1 with a 0x0000 tail → ocrc_err=4'b0000.
- LANES=4, mode 1, 0xFF payload per lane with the correct tail on lanes 0, 1, 3 and bit 7 flipped on lane 2 → ocrc_err=4'b0100 at odone.
- Mode 0 with ivalid toggling 1/0 every cycle → same CRC as the continuous case. Elapsed cycles are doubled, and ocrc holds during stalls.
- istart pulsed during CALC and during DONE → no restart; the result is identical to the undisturbed run.
- irst_n pulsed low at payload bit 500 → all outputs 0 immediately. A fresh istart then produces correct results with no odone from the aborted block.

Source files
------------

// File: rtl/sd_crc16_lanes.sv
`default_nettype none
// ============================================================================
//  Module   : sd_crc16_lanes
//  Purpose  : Per-DAT-line serial CRC16 (x^16 + x^12 + x^5 + 1, init 0)
//             engine for the SD data-line driver. Counts the block length
//             itself. In generate mode it shifts the CRC out after the
//             payload. In check mode it compares the received CRC tail
//             against the computed CRC and reports mismatches per lane.
//  Ports    : iclk        - clock, rising edge
//             irst_n      - asynchronous active-low reset
//             istart      - block start pulse, accepted from IDLE only
//             imode       - sampled with istart: 0 = generate, 1 = check
//             ivalid      - bit enable; the engine stalls when low
//             idata       - payload bit per lane, then CRC tail in check mode
//             ocrc        - CRC bit per lane during unload, MSB first
//             ocrc_valid  - high while ocrc carries CRC bits
//             obusy       - high while a block is in progress
//             odone       - one-cycle end-of-block pulse
//             ocrc_err    - sticky per-lane mismatch flags, held until istart
//  Revision : 1.0 - initial release
// ============================================================================
module sd_crc16_lanes #(
    parameter int LANES      = 4,
    parameter int BLOCK_BITS = 1024,
    parameter int CNT_W      = 11
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             istart,
    input  logic             imode,
    input  logic             ivalid,
    input  logic [LANES-1:0] idata,
    output logic [LANES-1:0] ocrc,
    output logic             ocrc_valid,
    output logic             obusy,
    output logic             odone,
    output logic [LANES-1:0] ocrc_err
);

    localparam logic [15:0]      POLY     = 16'h1021;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BLOCK_BITS - 1);
    localparam logic [3:0]       LAST_TAIL = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_UNLOAD = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       tail_cnt;
    logic             mode_chk;

    // ------------------------------------------------------------------
    // Sequencer: payload bit counter, 16-bit tail counter and mode latch.
    // ------------------------------------------------------------------
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            tail_cnt <= '0;
            mode_chk <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (istart) begin
                        bit_cnt  <= '0;
                        tail_cnt <= '0;
                        mode_chk <= imode;
                        state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (ivalid) begin
                        if (bit_cnt == LAST_BIT) begin
                            tail_cnt <= '0;
                            state    <= mode_chk ? S_CHECK : S_UNLOAD;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_UNLOAD, S_CHECK: begin
                    if (ivalid) begin
                        if (tail_cnt == LAST_TAIL) begin
                            state <= S_DONE;
                        end else begin
                            tail_cnt <= tail_cnt + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    // istart is deliberately not looked at here: a new block
                    // is only accepted once the engine is back in IDLE.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure decodes of the state register, so they change
    // only on clock edges and clear immediately with the asynchronous reset.
    assign ocrc_valid = (state == S_UNLOAD);
    assign obusy      = (state == S_CALC) || (state == S_UNLOAD) || (state == S_CHECK);
    assign odone      = (state == S_DONE);

    // ------------------------------------------------------------------
    // One fully independent CRC register and error flag per DAT line.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [15:0] crc;
        logic        err;
        logic        fb;

        assign fb = idata[g] ^ crc[15];

        always_ff @(posedge iclk or negedge irst_n) begin
            if (!irst_n) begin
                crc <= '0;
                err <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (istart) begin
                            crc <= '0;
                            err <= 1'b0;
                        end
                    end
                    S_CALC: begin
                        if (ivalid) begin
                            crc <= {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
                        end
                    end
                    S_UNLOAD: begin
                        // Shifting out MSB first; the vacated LSBs fill with 0.
                        if (ivalid) begin
                            crc <= {crc[14:0], 1'b0};
                        end
                    end
                    S_CHECK: begin
                        if (ivalid) begin
                            if (idata[g] != crc[15]) begin
                                err <= 1'b1;
                            end
                            crc <= {crc[14:0], 1'b0};
                        end
                    end
                    default: begin
                        crc <= crc;
                    end
                endcase
            end
        end

        assign ocrc[g]     = ocrc_valid & crc[15];
        assign ocrc_err[g] = err;
    end

endmodule
`default_nettype wire
